// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a program into the fetch-stage IMem through its newPC/write port,
// holding the CPU in reset until the last word lands, then releases at ENTRY_PC.
module imem_boot_loader #(
  parameter int          IMEM_SIZE = 256,
  parameter int          BASE_WORD = 0,
  parameter logic [31:0] ENTRY_PC  = 32'h0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_data_i,
  input  logic        in_last_i,
  output logic        in_ready_o,
  input  logic [31:0] cpu_newpc_i,
  output logic [31:0] if_newpc_o,
  output logic        if_we_o,
  output logic [31:0] if_wins_o,
  output logic        cpu_hold_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] word_count_o
);
  typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, RELEASE, DONE, ERR} state_t;
  localparam logic [15:0] BASE = 16'(BASE_WORD);
  localparam logic [15:0] LAST = 16'(IMEM_SIZE - 1);
  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d, wc_q, wc_d;
  logic [31:0] buf_q, buf_d;
  logic        lastf_q, lastf_d, done_q, done_d, err_q, err_d, own;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wc_d    = wc_q;
    buf_d   = buf_q;
    lastf_d = lastf_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      IDLE, DONE, ERR: if (start_i) begin
        state_d = ACCEPT;
        addr_d  = BASE;
        wc_d    = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
      end
      ACCEPT: if (in_valid_i) begin
        buf_d   = in_data_i;
        lastf_d = in_last_i;
        state_d = WRITE;
      end
      WRITE: begin
        wc_d = wc_q + 16'd1;
        if (lastf_q) state_d = RELEASE;
        else if (addr_q == LAST) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          addr_d  = addr_q + 16'd1;
          state_d = ACCEPT;
        end
      end
      RELEASE: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= BASE;
      wc_q    <= '0;
      buf_q   <= '0;
      lastf_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wc_q    <= wc_d;
      buf_q   <= buf_d;
      lastf_q <= lastf_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  // RST gates every strobe combinationally so a mid-load reset cannot land one more write
  assign own          = !RST && (state_q inside {ACCEPT, WRITE, RELEASE, ERR});
  assign cpu_hold_o   = own;
  assign in_ready_o   = !RST && state_q == ACCEPT;
  assign if_we_o      = !RST && state_q == WRITE;
  assign if_wins_o    = if_we_o ? buf_q : '0;
  assign if_newpc_o   = !own ? cpu_newpc_i : state_q == RELEASE ? ENTRY_PC : {14'b0, addr_q, 2'b00};
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign word_count_o = wc_q;
endmodule
